// File: rtl/lsu_align.sv
// Load/store alignment unit sitting between the RV32I execute stage and a
// word-only, little-endian data memory. Loads are sign/zero extended from the
// addressed lane, SB/SH become a read-modify-write, and bad accesses fault
// without ever touching memory.
module lsu_align #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_fault,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_add,
    output logic [DATA_WIDTH-1:0] mem_datain,
    input  logic [DATA_WIDTH-1:0] mem_dataout
);

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t                  stateQ, stateD;
    logic                    respValidQ, respValidD;
    logic                    respFaultQ, respFaultD;
    logic [DATA_WIDTH-1:0]   respRdataQ, respRdataD;
    logic [ADDR_WIDTH-1:0]   rmwAddrQ, rmwAddrD;
    logic [DATA_WIDTH-1:0]   mergedQ, mergedD;

    logic                    accept;
    logic                    fault;
    logic                    isHalf;
    logic                    isWord;
    logic                    legalFunct3;
    logic                    outOfRange;
    logic                    misaligned;
    logic [ADDR_WIDTH-1:0]   alignedAddr;
    logic [7:0]              loadByte;
    logic [15:0]             loadHalf;
    logic [DATA_WIDTH-1:0]   loadExt;
    logic [DATA_WIDTH-1:0]   mergedWord;

    assign req_ready   = (stateQ == IDLE) && !rst;
    assign accept      = req_valid && req_ready;
    assign alignedAddr = {req_addr[ADDR_WIDTH-1:2], 2'b00};
    assign resp_valid  = respValidQ;
    assign resp_fault  = respFaultQ;
    assign resp_rdata  = respRdataQ;

    // Classify the incoming request and decide whether it must fault.
    always_comb begin
        isHalf      = (req_funct3[1:0] == 2'b01);
        isWord      = (req_funct3[1:0] == 2'b10);
        legalFunct3 = 1'b0;
        if (req_we) begin
            legalFunct3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                          (req_funct3 == 3'b010);
        end else begin
            legalFunct3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                          (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                          (req_funct3 == 3'b101);
        end
        outOfRange = (req_addr[31:ADDR_WIDTH] != '0);
        misaligned = (isHalf && req_addr[0]) || (isWord && (req_addr[1:0] != 2'b00));
        fault      = !legalFunct3 || outOfRange || misaligned;
    end

    // Pick the addressed lane of the read word and extend it for loads, and
    // build the merged word that a sub-word store writes back.
    always_comb begin
        loadByte   = 8'h00;
        loadExt    = mem_dataout;
        mergedWord = mem_dataout;
        case (req_addr[1:0])
            2'b00:   loadByte = mem_dataout[7:0];
            2'b01:   loadByte = mem_dataout[15:8];
            2'b10:   loadByte = mem_dataout[23:16];
            default: loadByte = mem_dataout[31:24];
        endcase
        loadHalf = req_addr[1] ? mem_dataout[31:16] : mem_dataout[15:0];
        case (req_funct3)
            3'b000:  loadExt = {{24{loadByte[7]}}, loadByte};
            3'b001:  loadExt = {{16{loadHalf[15]}}, loadHalf};
            3'b100:  loadExt = {24'h000000, loadByte};
            3'b101:  loadExt = {16'h0000, loadHalf};
            default: loadExt = mem_dataout;
        endcase
        if (isHalf) begin
            if (req_addr[1]) mergedWord[31:16] = req_wdata[15:0];
            else             mergedWord[15:0]  = req_wdata[15:0];
        end else begin
            case (req_addr[1:0])
                2'b00:   mergedWord[7:0]   = req_wdata[7:0];
                2'b01:   mergedWord[15:8]  = req_wdata[7:0];
                2'b10:   mergedWord[23:16] = req_wdata[7:0];
                default: mergedWord[31:24] = req_wdata[7:0];
            endcase
        end
    end

    // Next-state, response and memory-control logic; reset silences memory.
    always_comb begin
        stateD     = stateQ;
        respValidD = 1'b0;
        respFaultD = respFaultQ;
        respRdataD = respRdataQ;
        rmwAddrD   = rmwAddrQ;
        mergedD    = mergedQ;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        mem_add    = '0;
        mem_datain = '0;
        case (stateQ)
            IDLE: begin
                if (req_valid) mem_add = alignedAddr;
                if (accept) begin
                    if (fault) begin
                        respValidD = 1'b1;
                        respFaultD = 1'b1;
                        respRdataD = '0;
                    end else if (!req_we) begin
                        mem_ren    = 1'b1;
                        respValidD = 1'b1;
                        respFaultD = 1'b0;
                        respRdataD = loadExt;
                    end else if (isWord) begin
                        mem_wen    = 1'b1;
                        mem_datain = req_wdata;
                        respValidD = 1'b1;
                        respFaultD = 1'b0;
                    end else begin
                        mem_ren  = 1'b1;
                        mergedD  = mergedWord;
                        rmwAddrD = alignedAddr;
                        stateD   = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                mem_wen    = 1'b1;
                mem_datain = mergedQ;
                mem_add    = rmwAddrQ;
                respValidD = 1'b1;
                respFaultD = 1'b0;
                stateD     = IDLE;
            end
            default: stateD = IDLE;
        endcase
        if (rst) begin
            mem_ren    = 1'b0;
            mem_wen    = 1'b0;
            mem_add    = '0;
            mem_datain = '0;
        end
    end

    // State and registered response fields, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ     <= IDLE;
            respValidQ <= 1'b0;
            respFaultQ <= 1'b0;
            respRdataQ <= '0;
            rmwAddrQ   <= '0;
            mergedQ    <= '0;
        end else begin
            stateQ     <= stateD;
            respValidQ <= respValidD;
            respFaultQ <= respFaultD;
            respRdataQ <= respRdataD;
            rmwAddrQ   <= rmwAddrD;
            mergedQ    <= mergedD;
        end
    end

endmodule
